// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad calculator: operator/state enums,
// 7-segment table, HD44780 command bytes, ASCII codes and a BCD helper.
package calc_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } calc_op_t;

    typedef enum logic [1:0] {
        ENTRY_A = 2'd0,
        ENTRY_B = 2'd1,
        RESULT  = 2'd2
    } calc_state_t;

    localparam logic [7:0] SEG_TABLE [0:9] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };

    localparam logic [7:0] LCD_CMD_FUNCTION = 8'h38;
    localparam logic [7:0] LCD_CMD_DISPLAY  = 8'h0C;
    localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2    = 8'hC0;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;
    localparam logic [7:0] ASCII_EQUAL = 8'h3D;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_R     = 8'h72;

    function automatic logic [7:0] seg_pattern(input logic [3:0] digit);
        if (digit <= 4'd9)
            return SEG_TABLE[digit];
        return 8'h00;
    endfunction

    function automatic logic [7:0] op_ascii(input calc_op_t op);
        case (op)
            ADD:     return ASCII_PLUS;
            SUB:     return ASCII_MINUS;
            MUL:     return ASCII_STAR;
            default: return ASCII_SLASH;
        endcase
    endfunction

    function automatic logic [3:0] op_led(input calc_op_t op);
        return 4'b0001 << op;
    endfunction

    // One double-dabble iteration over eight BCD nibbles: add-3 correction, then shift in a bit.
    function automatic logic [31:0] dabble_step(input logic [31:0] acc, input logic bit_in);
        logic [31:0] adj;
        adj = acc;
        for (int k = 0; k < 8; k++) begin
            if (adj[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
        end
        return 32'({adj, bit_in});
    endfunction

endpackage

// File: rtl/calc_lcd_ctrl.sv
// HD44780 8-bit write-only driver: init sequence, then endless refresh of two
// 16-character lines taken from a 32-byte buffer (byte 0 = line 1, column 0).
module calc_lcd_ctrl
    import calc_pkg::*;
#(
    parameter int LCD_E_CYCLES    = 20,
    parameter int LCD_WAIT_CYCLES = 200000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] char_buf,
    output logic [7:0]   lcd_data,
    output logic         lcd_e,
    output logic         lcd_rs
);

    localparam int CNT_MAX = (LCD_WAIT_CYCLES > LCD_E_CYCLES) ? LCD_WAIT_CYCLES : LCD_E_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        LCD_SETUP  = 2'd0,
        LCD_STROBE = 2'd1,
        LCD_HOLD   = 2'd2
    } lcd_state_t;

    lcd_state_t    state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [5:0]    step_q, step_n;
    logic          init_done_q, init_done_n;
    logic [7:0]    data_q, data_n;
    logic          rs_q, rs_n;
    logic [7:0]    cur_byte;
    logic          cur_rs;
    logic [4:0]    char_idx;

    // Refresh step 0 and 17 are the line-address commands; the rest are characters.
    always_comb begin
        cur_byte = LCD_CMD_CLEAR;
        cur_rs   = 1'b0;
        char_idx = '0;
        if (!init_done_q) begin
            case (step_q)
                6'd0:    cur_byte = LCD_CMD_FUNCTION;
                6'd1:    cur_byte = LCD_CMD_DISPLAY;
                6'd2:    cur_byte = LCD_CMD_ENTRY;
                default: cur_byte = LCD_CMD_CLEAR;
            endcase
        end else if (step_q == 6'd0) begin
            cur_byte = LCD_CMD_LINE1;
        end else if (step_q == 6'd17) begin
            cur_byte = LCD_CMD_LINE2;
        end else begin
            cur_rs   = 1'b1;
            char_idx = (step_q < 6'd17) ? 5'(step_q - 6'd1) : 5'(step_q - 6'd2);
            cur_byte = char_buf[{char_idx, 3'b000} +: 8];
        end
    end

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        step_n      = step_q;
        init_done_n = init_done_q;
        data_n      = data_q;
        rs_n        = rs_q;
        case (state_q)
            LCD_SETUP: begin
                data_n  = cur_byte;
                rs_n    = cur_rs;
                cnt_n   = '0;
                state_n = LCD_STROBE;
            end
            LCD_STROBE: begin
                if (cnt_q == CW'(LCD_E_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = LCD_HOLD;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            LCD_HOLD: begin
                if (cnt_q == CW'(LCD_WAIT_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = LCD_SETUP;
                    if (!init_done_q && step_q == 6'd3) begin
                        init_done_n = 1'b1;
                        step_n      = '0;
                    end else if (init_done_q && step_q == 6'd33) begin
                        step_n = '0;
                    end else begin
                        step_n = step_q + 6'd1;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: state_n = LCD_SETUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LCD_SETUP;
            cnt_q       <= '0;
            step_q      <= '0;
            init_done_q <= 1'b0;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            step_q      <= step_n;
            init_done_q <= init_done_n;
            data_q      <= data_n;
            rs_q        <= rs_n;
        end
    end

    assign lcd_data = data_q;
    assign lcd_rs   = rs_q;
    assign lcd_e    = (state_q == LCD_STROBE);

endmodule

// File: rtl/keypad_calculator.sv
// Four-function keypad calculator with 7-segment, LED and 16x2 LCD output.
// Define DEBOUNCE_EN to add a synchronizer + stable-time debouncer per button.
module keypad_calculator
    import calc_pkg::*;
#(
    parameter int LCD_E_CYCLES    = 20,
    parameter int LCD_WAIT_CYCLES = 200000
`ifdef DEBOUNCE_EN
    ,
    parameter int DEB_CYCLES      = 1000000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] i_sw_push,
    input  logic [7:0]  i_sw_dip,
    output logic [3:0]  o_led,
    output logic [7:0]  o_seg,
    output logic [7:0]  lcd_data,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic        lcd_rw
);

    logic [11:0] key_level_q, key_prev_q, key_rise;

`ifdef DEBOUNCE_EN
    localparam int DEB_CW = $clog2(DEB_CYCLES + 1);
    logic [11:0]       sync1_q, sync2_q;
    logic [DEB_CW-1:0] deb_cnt_q [12];

    // The level only flips after DEB_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            key_level_q <= '0;
            for (int i = 0; i < 12; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q <= i_sw_push;
            sync2_q <= sync1_q;
            for (int i = 0; i < 12; i++) begin
                if (sync2_q[i] == key_level_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_CW'(DEB_CYCLES - 1)) begin
                    key_level_q[i] <= sync2_q[i];
                    deb_cnt_q[i]   <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) key_level_q <= '0;
        else      key_level_q <= i_sw_push;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) key_prev_q <= '0;
        else      key_prev_q <= key_level_q;
    end

    assign key_rise = key_level_q & ~key_prev_q;

    logic       evt_any, is_digit, is_op, is_eq;
    logic [3:0] evt_idx, evt_digit;

    // Ascending scan, so the highest rising index is the one kept.
    always_comb begin
        evt_any = 1'b0;
        evt_idx = '0;
        for (int i = 0; i < 12; i++) begin
            if (key_rise[i]) begin
                evt_any = 1'b1;
                evt_idx = 4'(i);
            end
        end
    end

    assign is_digit  = evt_any && (evt_idx >= 4'd2);
    assign is_op     = evt_any && (evt_idx == 4'd1);
    assign is_eq     = evt_any && (evt_idx == 4'd0);
    assign evt_digit = 4'd11 - evt_idx;

    calc_state_t        state_q, state_n;
    calc_op_t           op_q, op_n;
    logic               op_valid_q, op_valid_n;
    logic signed [14:0] a_q, a_n, b_q, b_n;
    logic signed [27:0] result_q, result_n;
    logic               error_q, error_n;
    logic [7:0]         seg_q, seg_n;

    logic signed [27:0] a_ext, b_ext, alu_result;
    logic               div_zero;
    logic [27:0]        res_abs;
    logic [13:0]        trunc_mag;
    logic signed [14:0] trunc_a, digit_val;

    always_comb begin
        a_ext    = {{13{a_q[14]}}, a_q};
        b_ext    = {{13{b_q[14]}}, b_q};
        div_zero = (op_q == DIV) && (b_q == '0);
        case (op_q)
            ADD:     alu_result = a_ext + b_ext;
            SUB:     alu_result = a_ext - b_ext;
            MUL:     alu_result = a_ext * b_ext;
            default: alu_result = div_zero ? '0 : a_ext / b_ext;
        endcase
        res_abs   = result_q[27] ? -result_q : result_q;
        trunc_mag = 14'(res_abs % 28'd10000);
        trunc_a   = result_q[27] ? -$signed({1'b0, trunc_mag}) : $signed({1'b0, trunc_mag});
        digit_val = $signed({11'd0, evt_digit});
    end

    // Calculator sequencing; the clear switch overrides every key event.
    always_comb begin
        state_n    = state_q;
        op_n       = op_q;
        op_valid_n = op_valid_q;
        a_n        = a_q;
        b_n        = b_q;
        result_n   = result_q;
        error_n    = error_q;
        seg_n      = seg_q;
        if (i_sw_dip[7]) begin
            state_n    = ENTRY_A;
            op_n       = ADD;
            op_valid_n = 1'b0;
            a_n        = '0;
            b_n        = '0;
            result_n   = '0;
            error_n    = 1'b0;
            seg_n      = SEG_TABLE[0];
        end else if (is_digit) begin
            seg_n = seg_pattern(evt_digit);
            case (state_q)
                ENTRY_A: if (a_q < 15'sd1000) a_n = a_q * 15'sd10 + digit_val;
                ENTRY_B: if (b_q < 15'sd1000) b_n = b_q * 15'sd10 + digit_val;
                default: begin
                    state_n    = ENTRY_A;
                    op_n       = ADD;
                    op_valid_n = 1'b0;
                    a_n        = digit_val;
                    b_n        = '0;
                    result_n   = '0;
                    error_n    = 1'b0;
                end
            endcase
        end else if (is_op) begin
            op_n       = calc_op_t'(i_sw_dip[1:0]);
            op_valid_n = 1'b1;
            state_n    = ENTRY_B;
            if (state_q != ENTRY_B) b_n = '0;
            if (state_q == RESULT) begin
                a_n      = error_q ? 15'sd0 : trunc_a;
                error_n  = 1'b0;
                result_n = '0;
            end
        end else if (is_eq && state_q == ENTRY_B) begin
            result_n = alu_result;
            error_n  = div_zero;
            state_n  = RESULT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ENTRY_A;
            op_q       <= ADD;
            op_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            error_q    <= 1'b0;
            seg_q      <= SEG_TABLE[0];
        end else begin
            state_q    <= state_n;
            op_q       <= op_n;
            op_valid_q <= op_valid_n;
            a_q        <= a_n;
            b_q        <= b_n;
            result_q   <= result_n;
            error_q    <= error_n;
            seg_q      <= seg_n;
        end
    end

    assign o_seg  = seg_q;
    assign o_led  = op_valid_q ? op_led(op_q) : 4'b0000;
    assign lcd_rw = 1'b0;

    logic               unused_dip_bits;
    assign unused_dip_bits = ^i_sw_dip[6:2];

    logic signed [14:0] entry_val;
    logic [13:0]        entry_abs, last_entry_q, conv_sh_e;
    logic [26:0]        res_mag, last_res_q, conv_sh_r;
    logic               last_neg_q, conv_busy_q, result_neg_q;
    logic [15:0]        conv_acc_e, bcd_entry_q;
    logic [31:0]        conv_acc_r, bcd_result_q;
    logic [4:0]         conv_cnt_q;

    assign entry_val = (state_q == ENTRY_A) ? a_q : b_q;
    assign entry_abs = 14'(entry_val[14] ? -entry_val : entry_val);
    assign res_mag   = 27'(res_abs);

    // Both values run through one 27-step pass; the BCD outputs change only when it completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_entry_q <= '0;
            last_res_q   <= '0;
            last_neg_q   <= 1'b0;
            conv_sh_e    <= '0;
            conv_sh_r    <= '0;
            conv_acc_e   <= '0;
            conv_acc_r   <= '0;
            conv_cnt_q   <= '0;
            conv_busy_q  <= 1'b0;
            bcd_entry_q  <= '0;
            bcd_result_q <= '0;
            result_neg_q <= 1'b0;
        end else if (!conv_busy_q) begin
            if (entry_abs != last_entry_q || res_mag != last_res_q || result_q[27] != last_neg_q) begin
                last_entry_q <= entry_abs;
                last_res_q   <= res_mag;
                last_neg_q   <= result_q[27];
                conv_sh_e    <= entry_abs;
                conv_sh_r    <= res_mag;
                conv_acc_e   <= '0;
                conv_acc_r   <= '0;
                conv_cnt_q   <= '0;
                conv_busy_q  <= 1'b1;
            end
        end else begin
            if (conv_cnt_q < 5'd14) begin
                conv_acc_e <= 16'(dabble_step({16'd0, conv_acc_e}, conv_sh_e[13]));
                conv_sh_e  <= {conv_sh_e[12:0], 1'b0};
            end
            conv_acc_r <= dabble_step(conv_acc_r, conv_sh_r[26]);
            conv_sh_r  <= {conv_sh_r[25:0], 1'b0};
            conv_cnt_q <= conv_cnt_q + 5'd1;
            if (conv_cnt_q == 5'd26) begin
                conv_busy_q  <= 1'b0;
                bcd_entry_q  <= conv_acc_e;
                bcd_result_q <= dabble_step(conv_acc_r, conv_sh_r[26]);
                result_neg_q <= last_neg_q;
            end
        end
    end

    logic [15:0][7:0] line1_c, line2_c;
    logic             seen1, seen2;

    always_comb begin
        line1_c = {16{ASCII_SPACE}};
        line2_c = {16{ASCII_SPACE}};
        seen1   = 1'b0;
        seen2   = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (bcd_entry_q[4*i +: 4] != 4'd0 || i == 0) seen1 = 1'b1;
            if (seen1) line1_c[15-i] = ASCII_ZERO | {4'h0, bcd_entry_q[4*i +: 4]};
        end
        if (state_q == ENTRY_B) line1_c[0] = op_ascii(op_q);
        if (state_q == RESULT) begin
            if (error_q) begin
                line2_c[0] = ASCII_E;
                line2_c[1] = ASCII_R;
                line2_c[2] = ASCII_R;
            end else begin
                line2_c[0] = ASCII_EQUAL;
                line2_c[1] = result_neg_q ? ASCII_MINUS : ASCII_SPACE;
                for (int i = 7; i >= 0; i--) begin
                    if (bcd_result_q[4*i +: 4] != 4'd0 || i == 0) seen2 = 1'b1;
                    if (seen2) line2_c[9-i] = ASCII_ZERO | {4'h0, bcd_result_q[4*i +: 4]};
                end
            end
        end
    end

    calc_lcd_ctrl #(
        .LCD_E_CYCLES    (LCD_E_CYCLES),
        .LCD_WAIT_CYCLES (LCD_WAIT_CYCLES)
    ) u_lcd (
        .clk      (clk),
        .rst      (rst),
        .char_buf ({line2_c, line1_c}),
        .lcd_data (lcd_data),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs)
    );

endmodule

// File: tb/tb_keypad_calculator.sv
// Directed self-checking bench for keypad_calculator; an LCD bus monitor
// rebuilds the two display lines from the observed writes.
module tb_keypad_calculator;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] sw_push;
    logic [7:0]  sw_dip;
    logic [3:0]  led;
    logic [7:0]  seg;
    logic [7:0]  lcd_data;
    logic        lcd_e, lcd_rs, lcd_rw;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] lcd_line1 [16];
    logic [7:0] lcd_line2 [16];
    int         lcd_addr  = 0;
    int         e_len     = 0;
    int         e_min     = 1000;
    int         e_max     = 0;
    int         e_pulses  = 0;
    bit         rw_bad    = 1'b0;

    always #5 clk = ~clk;

    keypad_calculator #(
        .LCD_E_CYCLES    (3),
        .LCD_WAIT_CYCLES (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_sw_push (sw_push),
        .i_sw_dip  (sw_dip),
        .o_led     (led),
        .o_seg     (seg),
        .lcd_data  (lcd_data),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [11:0] keys, input int hold);
        @(negedge clk);
        sw_push = keys;
        repeat (hold) @(negedge clk);
        sw_push = '0;
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [11:0] keyMask(input int idx);
        logic [11:0] one;
        one = 12'd1;
        return one << idx;
    endfunction

    function automatic logic [127:0] packLine(input int which);
        logic [127:0] v;
        for (int c = 0; c < 16; c++)
            v[127-8*c -: 8] = (which == 1) ? lcd_line1[c] : lcd_line2[c];
        return v;
    endfunction

    // LCD bus monitor: decode each strobe into commands / DDRAM writes.
    always @(negedge clk) begin
        if (lcd_rw !== 1'b0) rw_bad = 1'b1;
        if (lcd_e === 1'b1) begin
            if (e_len == 0) begin
                if (!lcd_rs) begin
                    if (lcd_data == 8'h01) begin
                        for (int c = 0; c < 16; c++) begin
                            lcd_line1[c] = 8'h20;
                            lcd_line2[c] = 8'h20;
                        end
                        lcd_addr = 0;
                    end else if (lcd_data[7]) begin
                        lcd_addr = int'(lcd_data[6:0]);
                    end
                end else begin
                    if (lcd_addr < 16) lcd_line1[lcd_addr] = lcd_data;
                    else if (lcd_addr >= 64 && lcd_addr < 80) lcd_line2[lcd_addr-64] = lcd_data;
                    lcd_addr++;
                end
            end
            e_len++;
        end else if (e_len > 0) begin
            e_pulses++;
            if (e_len < e_min) e_min = e_len;
            if (e_len > e_max) e_max = e_len;
            e_len = 0;
        end
    end

    initial begin
        for (int c = 0; c < 16; c++) begin
            lcd_line1[c] = 8'h00;
            lcd_line2[c] = 8'h00;
        end
        rst     = 1'b0;
        sw_push = '0;
        sw_dip  = '0;
        waitCycles(3);
        checkOutput("reset_seg",    seg, 8'h3F);
        checkOutput("reset_led",    led, 4'b0000);
        checkOutput("reset_lcd_e",  lcd_e, 1'b0);
        checkOutput("reset_lcd_rs", lcd_rs, 1'b0);
        checkOutput("reset_data",   lcd_data, 8'h00);
        checkOutput("reset_state",  dut.state_q, 0);
        rst = 1'b1;
        waitCycles(1);

        applyStimulus(keyMask(9), 2);
        checkOutput("digit2_seg", seg, 8'h5B);
        checkOutput("digit2_led", led, 4'b0000);
        checkOutput("digit2_a",   int'(dut.a_q), 2);

        sw_dip = 8'h80;
        waitCycles(2);
        checkOutput("clear0_a", int'(dut.a_q), 0);
        sw_dip = 8'h00;
        waitCycles(2);

        // 12 + 34
        applyStimulus(keyMask(10), 2);
        applyStimulus(keyMask(9), 2);
        checkOutput("add_a", int'(dut.a_q), 12);
        applyStimulus(keyMask(1), 2);
        checkOutput("add_led",   led, 4'b0001);
        checkOutput("add_state", dut.state_q, 1);
        applyStimulus(keyMask(8), 2);
        applyStimulus(keyMask(7), 2);
        checkOutput("add_b", int'(dut.b_q), 34);
        waitCycles(800);
        checkOutput("add_line1", packLine(1), {"+", {13{" "}}, "34"});
        applyStimulus(keyMask(0), 2);
        checkOutput("add_result", int'(dut.result_q), 46);
        checkOutput("add_state2", dut.state_q, 2);
        waitCycles(800);
        checkOutput("add_line2", packLine(2), {"=", {7{" "}}, "46", {6{" "}}});
        checkOutput("add_line1r", packLine(1), {{14{" "}}, "34"});

        // 3 - 5
        applyStimulus(keyMask(8), 2);
        checkOutput("sub_a",       int'(dut.a_q), 3);
        checkOutput("sub_led_clr", led, 4'b0000);
        sw_dip = 8'h01;
        applyStimulus(keyMask(1), 2);
        checkOutput("sub_led", led, 4'b0010);
        applyStimulus(keyMask(6), 2);
        applyStimulus(keyMask(0), 2);
        checkOutput("sub_result", int'(dut.result_q), -2);
        waitCycles(800);
        checkOutput("sub_line2", packLine(2), {"=-", {7{" "}}, "2", {6{" "}}});

        // 9999 * 9999, fifth digit ignored
        repeat (5) applyStimulus(keyMask(2), 2);
        checkOutput("mul_a", int'(dut.a_q), 9999);
        sw_dip = 8'h02;
        applyStimulus(keyMask(1), 2);
        checkOutput("mul_led", led, 4'b0100);
        repeat (5) applyStimulus(keyMask(2), 2);
        checkOutput("mul_b", int'(dut.b_q), 9999);
        applyStimulus(keyMask(0), 2);
        checkOutput("mul_result", int'(dut.result_q), 99980001);
        waitCycles(800);
        checkOutput("mul_line2", packLine(2), {"= 99980001", {6{" "}}});

        // 7 / 0
        applyStimulus(keyMask(4), 2);
        sw_dip = 8'h03;
        applyStimulus(keyMask(1), 2);
        applyStimulus(keyMask(11), 2);
        applyStimulus(keyMask(0), 2);
        checkOutput("div0_error",  dut.error_q, 1'b1);
        checkOutput("div0_result", int'(dut.result_q), 0);
        checkOutput("div0_led",    led, 4'b1000);
        waitCycles(800);
        checkOutput("div0_line2", packLine(2), {"Err", {13{" "}}});

        sw_dip = 8'h80;
        waitCycles(2);
        checkOutput("clear_led",   led, 4'b0000);
        checkOutput("clear_state", dut.state_q, 0);
        checkOutput("clear_error", dut.error_q, 1'b0);
        sw_dip = 8'h00;
        waitCycles(2);

        // push[7] is digit 4; holding it must enter it only once
        applyStimulus(keyMask(7), 100);
        checkOutput("hold_a",   int'(dut.a_q), 4);
        checkOutput("hold_seg", seg, 8'h66);

        // digits 1 (push[10]) and 6 (push[5]) together: index 10 wins
        applyStimulus(keyMask(10) | keyMask(5), 2);
        checkOutput("simul_a",   int'(dut.a_q), 41);
        checkOutput("simul_seg", seg, 8'h06);

        applyStimulus(keyMask(0), 2);
        checkOutput("eq_ignored_state", dut.state_q, 0);
        checkOutput("eq_ignored_a",     int'(dut.a_q), 41);

        checkOutput("lcd_e_seen",  (e_pulses > 0), 1'b1);
        checkOutput("lcd_e_min",   e_min, 3);
        checkOutput("lcd_e_max",   e_max, 3);
        checkOutput("lcd_rw_zero", rw_bad, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
